// File: rtl/decode_queue_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_stage_pkg
//  Description : Shared opcodes, control-bundle layout and decode helpers for
//                the buffered RV64I decode stage.
//  Revision    : 1.0
// ============================================================================
package decode_queue_stage_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int ALU_OP_W  = 16;
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLL   = 2;
    localparam int ALU_SLT   = 3;
    localparam int ALU_SLTU  = 4;
    localparam int ALU_XOR   = 5;
    localparam int ALU_SRL   = 6;
    localparam int ALU_SRA   = 7;
    localparam int ALU_OR    = 8;
    localparam int ALU_AND   = 9;
    localparam int ALU_ADDW  = 10;
    localparam int ALU_SUBW  = 11;
    localparam int ALU_SLLW  = 12;
    localparam int ALU_SRLW  = 13;
    localparam int ALU_SRAW  = 14;
    localparam int ALU_PASSB = 15;

    localparam int RD_SRC_ALU = 0;
    localparam int RD_SRC_MEM = 1;
    localparam int RD_SRC_PC4 = 2;

    localparam int BR_EQ  = 0;
    localparam int BR_NE  = 1;
    localparam int BR_LT  = 2;
    localparam int BR_GE  = 3;
    localparam int BR_LTU = 4;
    localparam int BR_GEU = 5;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_e;

    typedef struct packed {
        logic [4:0]          rs1_idx;
        logic                rs1_used;
        logic [4:0]          rs2_idx;
        logic                rs2_used;
        logic [4:0]          rd_idx;
        logic                rd_wr_en;
        logic [2:0]          rd_src_1h;
        logic [ALU_OP_W-1:0] alu_op_1h;
        logic [3:0]          mem_width_1h;
        logic                mem_rd;
        logic                mem_wr;
        logic                mem_sign;
        logic                pc_src;
        logic [5:0]          br_cond_1h;
        logic                illegal;
    } dec_ctrl_t;

    localparam int DEC_CTRL_W = $bits(dec_ctrl_t);

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32,
            OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    // alt selects SUB/SRA variants; word selects the 32-bit W forms.
    function automatic logic [ALU_OP_W-1:0] alu_op_onehot(input logic [2:0] f3,
                                                          input logic       alt,
                                                          input logic       word);
        logic [ALU_OP_W-1:0] r;
        r = '0;
        if (word) begin
            case (f3)
                3'b001:  r[ALU_SLLW] = 1'b1;
                3'b101:  r[alt ? ALU_SRAW : ALU_SRLW] = 1'b1;
                3'b000:  r[alt ? ALU_SUBW : ALU_ADDW] = 1'b1;
                default: r[ALU_ADDW] = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000:  r[alt ? ALU_SUB : ALU_ADD] = 1'b1;
                3'b001:  r[ALU_SLL]  = 1'b1;
                3'b010:  r[ALU_SLT]  = 1'b1;
                3'b011:  r[ALU_SLTU] = 1'b1;
                3'b100:  r[ALU_XOR]  = 1'b1;
                3'b101:  r[alt ? ALU_SRA : ALU_SRL] = 1'b1;
                3'b110:  r[ALU_OR]   = 1'b1;
                default: r[ALU_AND]  = 1'b1;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_stage_if
//  Description : Fetch-side, regfile and execute-side signals of the decode
//                stage; slave is the stage, master is its environment.
//  Revision    : 1.0
// ============================================================================
interface decode_queue_stage_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    import decode_queue_stage_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             squash_i;
    logic             fetch_valid_i;
    logic             fetch_ready_o;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  next_pc_i;
    logic [31:0]      inst_i;
    logic [4:0]       rs1_idx_ao;
    logic [4:0]       rs2_idx_ao;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  next_pc_o;
    dec_ctrl_t        dec_ctrl_o;
    logic [XLEN-1:0]  rs1_data_o;
    logic [XLEN-1:0]  rs2_data_o;
    logic [XLEN-1:0]  alu_op_a_o;
    logic [XLEN-1:0]  alu_op_b_o;
    logic [CNT_W-1:0] count_o;

    modport master (
        output squash_i, fetch_valid_i, pc_i, next_pc_i, inst_i,
               rs1_data_i, rs2_data_i, ready_i,
        input  fetch_ready_o, rs1_idx_ao, rs2_idx_ao, valid_o, pc_o, next_pc_o,
               dec_ctrl_o, rs1_data_o, rs2_data_o, alu_op_a_o, alu_op_b_o, count_o
    );

    modport slave (
        input  squash_i, fetch_valid_i, pc_i, next_pc_i, inst_i,
               rs1_data_i, rs2_data_i, ready_i,
        output fetch_ready_o, rs1_idx_ao, rs2_idx_ao, valid_o, pc_o, next_pc_o,
               dec_ctrl_o, rs1_data_o, rs2_data_o, alu_op_a_o, alu_op_b_o, count_o
    );

endinterface
`default_nettype wire

// File: rtl/decode_queue_stage_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_stage_decoder
//  Description : Combinational RV64I field decode, immediate generation and
//                ALU operand selection for one instruction.
//  Revision    : 1.0
// ============================================================================
module decode_queue_stage_decoder
    import decode_queue_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output dec_ctrl_t       o_ctrl,
    output logic [XLEN-1:0] o_alu_op_a,
    output logic [XLEN-1:0] o_alu_op_b
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm;
    op_a_sel_e       w_a_sel;
    logic            w_b_imm;
    logic            w_rd_wr;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_shift_alt;
    dec_ctrl_t       w_ctrl;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];

    assign w_imm_i = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                      i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                      i_inst[20], i_inst[30:21], 1'b0};

    // Immediate forms only carry a SUB/SRA selector on right shifts.
    assign w_shift_alt = (w_funct3 == 3'b101) & i_inst[30];

    always_comb begin
        w_ctrl     = '0;
        w_imm      = '0;
        w_a_sel    = OPA_RS1;
        w_b_imm    = 1'b0;
        w_rd_wr    = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_rd_wr                      = 1'b1;
                w_ctrl.rd_src_1h[RD_SRC_ALU] = 1'b1;
                w_ctrl.alu_op_1h[ALU_PASSB]  = 1'b1;
                w_a_sel                      = OPA_ZERO;
                w_imm                        = w_imm_u;
                w_b_imm                      = 1'b1;
            end
            OPC_AUIPC: begin
                w_rd_wr                      = 1'b1;
                w_ctrl.rd_src_1h[RD_SRC_ALU] = 1'b1;
                w_ctrl.alu_op_1h[ALU_ADD]    = 1'b1;
                w_a_sel                      = OPA_PC;
                w_imm                        = w_imm_u;
                w_b_imm                      = 1'b1;
            end
            OPC_JAL: begin
                w_rd_wr                      = 1'b1;
                w_ctrl.rd_src_1h[RD_SRC_PC4] = 1'b1;
                w_ctrl.pc_src                = 1'b1;
                w_ctrl.alu_op_1h[ALU_ADD]    = 1'b1;
                w_a_sel                      = OPA_PC;
                w_imm                        = w_imm_j;
                w_b_imm                      = 1'b1;
            end
            OPC_JALR: begin
                w_rd_wr                      = 1'b1;
                w_rs1_used                   = 1'b1;
                w_ctrl.rd_src_1h[RD_SRC_PC4] = 1'b1;
                w_ctrl.pc_src                = 1'b1;
                w_ctrl.alu_op_1h[ALU_ADD]    = 1'b1;
                w_imm                        = w_imm_i;
                w_b_imm                      = 1'b1;
            end
            OPC_BRANCH: begin
                w_rs1_used                = 1'b1;
                w_rs2_used                = 1'b1;
                w_ctrl.alu_op_1h[ALU_SUB] = 1'b1;
                w_imm                     = w_imm_b;
                case (w_funct3)
                    3'b000:  w_ctrl.br_cond_1h[BR_EQ]  = 1'b1;
                    3'b001:  w_ctrl.br_cond_1h[BR_NE]  = 1'b1;
                    3'b100:  w_ctrl.br_cond_1h[BR_LT]  = 1'b1;
                    3'b101:  w_ctrl.br_cond_1h[BR_GE]  = 1'b1;
                    3'b110:  w_ctrl.br_cond_1h[BR_LTU] = 1'b1;
                    3'b111:  w_ctrl.br_cond_1h[BR_GEU] = 1'b1;
                    default: w_ctrl.br_cond_1h         = '0;
                endcase
            end
            OPC_LOAD: begin
                w_rd_wr                      = 1'b1;
                w_rs1_used                   = 1'b1;
                w_ctrl.rd_src_1h[RD_SRC_MEM] = 1'b1;
                w_ctrl.alu_op_1h[ALU_ADD]    = 1'b1;
                w_ctrl.mem_rd                = 1'b1;
                w_ctrl.mem_width_1h          = 4'b0001 << w_funct3[1:0];
                w_ctrl.mem_sign              = ~w_funct3[2];
                w_imm                        = w_imm_i;
                w_b_imm                      = 1'b1;
            end
            OPC_STORE: begin
                w_rs1_used                = 1'b1;
                w_rs2_used                = 1'b1;
                w_ctrl.alu_op_1h[ALU_ADD] = 1'b1;
                w_ctrl.mem_wr             = 1'b1;
                w_ctrl.mem_width_1h       = 4'b0001 << w_funct3[1:0];
                w_imm                     = w_imm_s;
                w_b_imm                   = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                w_rd_wr                      = 1'b1;
                w_rs1_used                   = 1'b1;
                w_ctrl.rd_src_1h[RD_SRC_ALU] = 1'b1;
                w_ctrl.alu_op_1h             = alu_op_onehot(w_funct3, w_shift_alt,
                                                             w_opcode == OPC_OP_IMM_32);
                w_imm                        = w_imm_i;
                w_b_imm                      = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                w_rd_wr                      = 1'b1;
                w_rs1_used                   = 1'b1;
                w_rs2_used                   = 1'b1;
                w_ctrl.rd_src_1h[RD_SRC_ALU] = 1'b1;
                w_ctrl.alu_op_1h             = alu_op_onehot(w_funct3, i_inst[30],
                                                             w_opcode == OPC_OP_32);
            end
            default: begin
                w_ctrl.alu_op_1h = '0;
            end
        endcase

        w_ctrl.illegal  = ~is_legal_opcode(w_opcode);
        w_ctrl.rs1_used = w_rs1_used;
        w_ctrl.rs2_used = w_rs2_used;
        w_ctrl.rs1_idx  = w_rs1_used ? i_inst[19:15] : 5'd0;
        w_ctrl.rs2_idx  = w_rs2_used ? i_inst[24:20] : 5'd0;
        w_ctrl.rd_wr_en = w_rd_wr & (i_inst[11:7] != 5'd0);
        w_ctrl.rd_idx   = w_rd_wr ? i_inst[11:7] : 5'd0;
    end

    always_comb begin
        case (w_a_sel)
            OPA_PC:   o_alu_op_a = i_pc;
            OPA_ZERO: o_alu_op_a = '0;
            default:  o_alu_op_a = i_rs1_data;
        endcase
    end

    assign o_alu_op_b = w_b_imm ? w_imm : i_rs2_data;
    assign o_ctrl     = w_ctrl;

endmodule
`default_nettype wire

// File: rtl/decode_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_stage
//  Description : Buffered RV64I decode stage: fetch FIFO with empty-bypass,
//                decoder, operand read and a valid/ready output register.
//  Revision    : 1.0
// ============================================================================
module decode_queue_stage
    import decode_queue_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    decode_queue_stage_if.slave  dq_bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  r_pc_mem   [DEPTH];
    logic [XLEN-1:0]  r_npc_mem  [DEPTH];
    logic [31:0]      r_inst_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_rst_done;

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_npc;
    dec_ctrl_t        r_ctrl;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_alu_a;
    logic [XLEN-1:0]  r_alu_b;

    logic             w_empty;
    logic             w_full;
    logic             w_fetch_ready;
    logic             w_out_free;
    logic             w_load;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic [XLEN-1:0]  w_src_pc;
    logic [XLEN-1:0]  w_src_npc;
    logic [31:0]      w_src_inst;
    dec_ctrl_t        w_ctrl;
    logic [XLEN-1:0]  w_alu_a;
    logic [XLEN-1:0]  w_alu_b;

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CNT_W'(DEPTH));
    // r_rst_done keeps the stage closed to fetch until the first edge after reset.
    assign w_fetch_ready = r_rst_done & ~w_full;
    assign w_out_free    = ~r_valid | dq_bus.ready_i;
    assign w_load        = w_out_free & ~dq_bus.squash_i &
                           (~w_empty | (dq_bus.fetch_valid_i & w_fetch_ready));
    assign w_bypass      = w_load & w_empty;
    assign w_push        = dq_bus.fetch_valid_i & w_fetch_ready & ~dq_bus.squash_i & ~w_bypass;
    assign w_pop         = w_load & ~w_empty;

    assign w_src_pc   = w_empty ? dq_bus.pc_i      : r_pc_mem[r_rd_ptr];
    assign w_src_npc  = w_empty ? dq_bus.next_pc_i : r_npc_mem[r_rd_ptr];
    assign w_src_inst = w_empty ? dq_bus.inst_i    : r_inst_mem[r_rd_ptr];

    decode_queue_stage_decoder #(
        .XLEN (XLEN)
    ) u_decoder (
        .i_inst     (w_src_inst),
        .i_pc       (w_src_pc),
        .i_rs1_data (dq_bus.rs1_data_i),
        .i_rs2_data (dq_bus.rs2_data_i),
        .o_ctrl     (w_ctrl),
        .o_alu_op_a (w_alu_a),
        .o_alu_op_b (w_alu_b)
    );

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= dq_bus.pc_i;
            r_npc_mem[r_wr_ptr]  <= dq_bus.next_pc_i;
            r_inst_mem[r_wr_ptr] <= dq_bus.inst_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (dq_bus.squash_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_npc      <= '0;
            r_ctrl     <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
        end else if (dq_bus.squash_i) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_pc       <= w_src_pc;
            r_npc      <= w_src_npc;
            r_ctrl     <= w_ctrl;
            r_rs1_data <= dq_bus.rs1_data_i;
            r_rs2_data <= dq_bus.rs2_data_i;
            r_alu_a    <= w_alu_a;
            r_alu_b    <= w_alu_b;
        end else if (dq_bus.ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign dq_bus.fetch_ready_o = w_fetch_ready;
    assign dq_bus.rs1_idx_ao    = w_load ? w_ctrl.rs1_idx : 5'd0;
    assign dq_bus.rs2_idx_ao    = w_load ? w_ctrl.rs2_idx : 5'd0;
    assign dq_bus.valid_o       = r_valid;
    assign dq_bus.pc_o          = r_pc;
    assign dq_bus.next_pc_o     = r_npc;
    assign dq_bus.dec_ctrl_o    = r_ctrl;
    assign dq_bus.rs1_data_o    = r_rs1_data;
    assign dq_bus.rs2_data_o    = r_rs2_data;
    assign dq_bus.alu_op_a_o    = r_alu_a;
    assign dq_bus.alu_op_b_o    = r_alu_b;
    assign dq_bus.count_o       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_queue_stage
//  Description : Scoreboard bench for decode_queue_stage.
//  Revision    : 1.0
// ============================================================================
module tb_decode_queue_stage;
    import decode_queue_stage_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
    } sb_item_t;

    logic     clk;
    logic     rst_ni;
    int       n_checks = 0;
    int       n_fail   = 0;
    sb_item_t sb[$];
    sb_item_t it;
    bit       stream_done;

    decode_queue_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    decode_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .dq_bus (bus)
    );

    function automatic logic [63:0] rf(input logic [4:0] idx);
        return (idx == 5'd0) ? 64'd0 : (64'hCAFE_0000_0000_0000 | 64'(idx));
    endfunction

    function automatic logic [31:0] addi_x1(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    assign bus.rs1_data_i = rf(bus.rs1_idx_ao);
    assign bus.rs2_data_i = rf(bus.rs2_idx_ao);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] pc, input logic [31:0] inst);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.fetch_valid_i = 1'b1;
        bus.pc_i          = pc;
        bus.next_pc_i     = pc + 64'd4;
        bus.inst_i        = inst;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.fetch_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        bus.fetch_valid_i = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on fetch handshake, pop and compare on execute handshake.
    always @(negedge clk) begin
        if (!rst_ni || bus.squash_i) begin
            sb.delete();
        end else begin
            if (bus.valid_o && bus.ready_i) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    it = sb.pop_front();
                    check("sb_pc", bus.pc_o, it.pc);
                    check("sb_next_pc", bus.next_pc_o, it.npc);
                end
            end else if (bus.valid_o) begin
                if (sb.size() == 0) check("hold_underflow", 64'd1, 64'd0);
                else                check("hold_pc", bus.pc_o, sb[0].pc);
            end
            if (bus.fetch_valid_i && bus.fetch_ready_o) begin
                it.pc  = bus.pc_i;
                it.npc = bus.next_pc_i;
                sb.push_back(it);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni            = 1'b1;
        bus.squash_i      = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.pc_i          = '0;
        bus.next_pc_i     = '0;
        bus.inst_i        = '0;
        bus.ready_i       = 1'b0;
        stream_done       = 1'b0;
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetch_ready", 64'(bus.fetch_ready_o), 64'd0);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_ctrl", 64'(bus.dec_ctrl_o), 64'd0);
        check("rst_alu_b", bus.alu_op_b_o, 64'd0);
        rst_ni = 1'b1;
        cycle();
        check("post_rst_fetch_ready", 64'(bus.fetch_ready_o), 64'd1);

        // Bypass into an empty stage
        bus.ready_i = 1'b1;
        send(64'h1000, 32'h0050_0093);
        check("byp_valid", 64'(bus.valid_o), 64'd1);
        check("byp_rd_idx", 64'(bus.dec_ctrl_o.rd_idx), 64'd1);
        check("byp_rd_wr_en", 64'(bus.dec_ctrl_o.rd_wr_en), 64'd1);
        check("byp_alu_b", bus.alu_op_b_o, 64'd5);
        check("byp_alu_a", bus.alu_op_a_o, 64'd0);
        check("byp_count", 64'(bus.count_o), 64'd0);
        check("byp_pc", bus.pc_o, 64'h1000);
        cycle();
        check("idle_valid", 64'(bus.valid_o), 64'd0);

        // Register-register, store and jump decode
        send(64'h1100, 32'h0020_81B3);
        check("add_rs1_data", bus.rs1_data_o, 64'hCAFE_0000_0000_0001);
        check("add_rs2_data", bus.rs2_data_o, 64'hCAFE_0000_0000_0002);
        check("add_alu_b", bus.alu_op_b_o, 64'hCAFE_0000_0000_0002);
        check("add_alu_op", 64'(bus.dec_ctrl_o.alu_op_1h), 64'd1 << ALU_ADD);
        send(64'h1104, 32'h0011_2023);
        check("sw_mem_wr", 64'(bus.dec_ctrl_o.mem_wr), 64'd1);
        check("sw_rd_wr_en", 64'(bus.dec_ctrl_o.rd_wr_en), 64'd0);
        check("sw_width", 64'(bus.dec_ctrl_o.mem_width_1h), 64'b0100);
        check("sw_rs2_idx", 64'(bus.dec_ctrl_o.rs2_idx), 64'd1);
        send(64'h1108, 32'h0080_00EF);
        check("jal_pc_src", 64'(bus.dec_ctrl_o.pc_src), 64'd1);
        check("jal_alu_a", bus.alu_op_a_o, 64'h1108);
        check("jal_alu_b", bus.alu_op_b_o, 64'd8);
        check("jal_rs1_idx", 64'(bus.dec_ctrl_o.rs1_idx), 64'd0);
        cycle();

        // Fill: one instruction in the output register, DEPTH in the FIFO
        bus.ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send(64'h2000 + 64'(4 * i), addi_x1(12'(i)));
        check("fill_count", 64'(bus.count_o), 64'(DEPTH));
        check("fill_fetch_ready", 64'(bus.fetch_ready_o), 64'd0);
        bus.fetch_valid_i = 1'b1;
        bus.pc_i          = 64'h2FFF;
        bus.next_pc_i     = 64'h3003;
        repeat (3) cycle();
        bus.fetch_valid_i = 1'b0;
        check("fill_6th_rejected", 64'(bus.count_o), 64'(DEPTH));
        bus.ready_i = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("drain_valid", 64'(bus.valid_o), 64'd1);
            check("drain_pc", bus.pc_o, 64'h2000 + 64'(4 * i));
            cycle();
        end
        check("drain_empty_valid", 64'(bus.valid_o), 64'd0);
        check("drain_count", 64'(bus.count_o), 64'd0);

        // Squash when full, with a same-cycle fetch offer
        bus.ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send(64'h3000 + 64'(4 * i), addi_x1(12'(i)));
        bus.squash_i      = 1'b1;
        bus.ready_i       = 1'b1;
        bus.fetch_valid_i = 1'b1;
        bus.pc_i          = 64'h3100;
        bus.next_pc_i     = 64'h3104;
        bus.inst_i        = addi_x1(12'd7);
        cycle();
        bus.squash_i      = 1'b0;
        bus.fetch_valid_i = 1'b0;
        check("sq_valid", 64'(bus.valid_o), 64'd0);
        check("sq_count", 64'(bus.count_o), 64'd0);
        check("sq_fetch_ready", 64'(bus.fetch_ready_o), 64'd1);
        repeat (2) cycle();
        check("sq_offer_lost", 64'(bus.valid_o), 64'd0);

        // Illegal encodings
        send(64'h4000, 32'h0000_0000);
        check("ill0_illegal", 64'(bus.dec_ctrl_o.illegal), 64'd1);
        check("ill0_rd_wr_en", 64'(bus.dec_ctrl_o.rd_wr_en), 64'd0);
        check("ill0_mem_wr", 64'(bus.dec_ctrl_o.mem_wr), 64'd0);
        send(64'h4004, 32'h0000_007F);
        check("ill7f_illegal", 64'(bus.dec_ctrl_o.illegal), 64'd1);
        check("ill7f_rd_wr_en", 64'(bus.dec_ctrl_o.rd_wr_en), 64'd0);
        check("ill7f_mem_wr", 64'(bus.dec_ctrl_o.mem_wr), 64'd0);
        check("ill7f_pc_src", 64'(bus.dec_ctrl_o.pc_src), 64'd0);
        cycle();

        // Pointer wrap under random backpressure
        fork
            begin
                for (int i = 0; i < 2 * DEPTH + 3; i++)
                    send(64'h5000 + 64'(4 * i), addi_x1(12'(i)));
                stream_done = 1'b1;
            end
            begin
                for (int c = 0; c < 2000 && !stream_done; c++) begin
                    @(posedge clk);
                    #1;
                    bus.ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.ready_i = 1'b1;
        repeat (DEPTH + 3) cycle();
        check("wrap_drained", 64'(sb.size()), 64'd0);
        check("wrap_count", 64'(bus.count_o), 64'd0);

        // Asynchronous reset with entries in flight
        bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(64'h6000 + 64'(4 * i), addi_x1(12'(i)));
        check("mr_count", 64'(bus.count_o), 64'd3);
        #2 rst_ni = 1'b0;
        #1;
        check("mr_valid", 64'(bus.valid_o), 64'd0);
        check("mr_count_0", 64'(bus.count_o), 64'd0);
        check("mr_pc", bus.pc_o, 64'd0);
        check("mr_alu_b", bus.alu_op_b_o, 64'd0);
        check("mr_fetch_ready", 64'(bus.fetch_ready_o), 64'd0);
        repeat (2) cycle();
        rst_ni      = 1'b1;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("mr_no_stale", 64'(bus.valid_o), 64'd0);
        end
        check("mr_end_count", 64'(bus.count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
